// File: rtl/wall_follower_ctrl.sv
// -----------------------------------------------------------------------------
// wall_follower_ctrl
//   Wall-following navigation controller. Raw wall sensors are synchronised
//   and debounced, then drive a Moore FSM that follows the wall on the chosen
//   side (left- or right-hand rule) using timed in-place turns, a short forward
//   re-attach step after turning toward the wall, and dead-end detection.
//
// Parameters
//   DEBOUNCE     cycles a synced sensor must differ before the debounced copy follows
//   TURN_CYCLES  cycles each turn manoeuvre lasts
//   STEP_CYCLES  cycles of forward motion after a turn toward the wall
//   MAX_TURNS    consecutive turns allowed before declaring STUCK
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   enable        in   1 = run, 0 = return to IDLE
//   hand_sel      in   0 = left-hand rule, 1 = right-hand rule (sampled leaving IDLE)
//   front_sensor  in   raw, asynchronous: wall ahead
//   left_sensor   in   raw, asynchronous: wall on the left
//   right_sensor  in   raw, asynchronous: wall on the right
//   front         out  drive forward
//   turn          out  rotate in place
//   turn_dir      out  0 = rotate left, 1 = rotate right (0 when not turning)
//   halted        out  1 while STUCK
//   state_o       out  current state encoding for debug
// -----------------------------------------------------------------------------
module wall_follower_ctrl #(
  parameter int DEBOUNCE    = 4,
  parameter int TURN_CYCLES = 8,
  parameter int STEP_CYCLES = 4,
  parameter int MAX_TURNS   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       hand_sel,
  input  logic       front_sensor,
  input  logic       left_sensor,
  input  logic       right_sensor,
  output logic       front,
  output logic       turn,
  output logic       turn_dir,
  output logic       halted,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SEEK        = 3'd1,
    S_TRACK       = 3'd2,
    S_TURN_AWAY   = 3'd3,
    S_TURN_TOWARD = 3'd4,
    S_STEP        = 3'd5,
    S_STUCK       = 3'd6
  } state_t;

  localparam int DB_W    = $clog2(DEBOUNCE + 1);
  localparam int TMR_MAX = (TURN_CYCLES > STEP_CYCLES) ? TURN_CYCLES : STEP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TC_W    = $clog2(MAX_TURNS + 1);

  // Sensor bit order used throughout: [0]=front, [1]=left, [2]=right.
  logic [2:0]      w_raw;
  logic [2:0]      r_sync1;
  logic [2:0]      r_sync2;
  logic [2:0]      r_deb;
  logic [DB_W-1:0] r_db_cnt [3];

  state_t           r_state;
  state_t           w_next;
  logic             r_hand_q;
  logic             w_hand_next;
  logic [TMR_W-1:0] r_timer;
  logic [TC_W-1:0]  r_turn_cnt;

  logic w_f;
  logic w_s;
  logic w_turn_done;
  logic w_step_done;
  logic w_turn_start;
  logic w_entry;

  logic r_front, r_turn, r_turn_dir, r_halted;
  logic w_front, w_turn, w_turn_dir, w_halted;

  assign w_raw = {right_sensor, left_sensor, front_sensor};

  // ---------------------------------------------------------------------------
  // Input path: 2-flop synchroniser, then a per-sensor debounce counter that
  // only lets the debounced copy follow after DEBOUNCE consecutive differing
  // samples.
  // ---------------------------------------------------------------------------
  // NOTE: every flop here (and below) uses <= so all registers sample the
  // pre-edge values of each other; blocking assignments would collapse the
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_f         = r_deb[0];
  assign w_s         = r_hand_q ? r_deb[2] : r_deb[1];
  assign w_turn_done = (r_timer == TMR_W'(TURN_CYCLES - 1));
  assign w_step_done = (r_timer == TMR_W'(STEP_CYCLES - 1));
  assign w_hand_next = (r_state == S_IDLE && enable) ? hand_sel : r_hand_q;

  // ---------------------------------------------------------------------------
  // Next-state logic. w_turn_start flags the start of a new turn manoeuvre,
  // including TURN_AWAY re-entering itself, so the turn budget and the timer
  // can react to self re-entry too.
  // ---------------------------------------------------------------------------
  // NOTE: all outputs of this block get a default first so no path leaves
  // them unassigned, which would otherwise infer latches.
  always_comb begin
    w_next       = r_state;
    w_turn_start = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next = S_SEEK;
      end
      S_SEEK: begin
        if (w_f) begin
          w_next       = S_TURN_AWAY;
          w_turn_start = 1'b1;
        end else if (w_s) begin
          w_next = S_TRACK;
        end
      end
      S_TRACK: begin
        if (w_f) begin
          w_next       = S_TURN_AWAY;
          w_turn_start = 1'b1;
        end else if (!w_s) begin
          w_next       = S_TURN_TOWARD;
          w_turn_start = 1'b1;
        end
      end
      S_TURN_AWAY: begin
        if (w_turn_done) begin
          if (w_f) begin
            w_next       = S_TURN_AWAY;
            w_turn_start = 1'b1;
          end else begin
            w_next = w_s ? S_TRACK : S_SEEK;
          end
        end
      end
      S_TURN_TOWARD: begin
        if (w_turn_done) w_next = S_STEP;
      end
      S_STEP: begin
        if (w_f) begin
          w_next       = S_TURN_AWAY;
          w_turn_start = 1'b1;
        end else if (w_step_done) begin
          if (w_s) begin
            w_next = S_TRACK;
          end else begin
            w_next       = S_TURN_TOWARD;
            w_turn_start = 1'b1;
          end
        end
      end
      S_STUCK: begin
        w_next = S_STUCK;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Out of turn budget: the turn that would exceed it becomes STUCK.
    if (w_turn_start && (r_turn_cnt >= TC_W'(MAX_TURNS))) begin
      w_next       = S_STUCK;
      w_turn_start = 1'b0;
    end

    if (!enable) begin
      w_next       = S_IDLE;
      w_turn_start = 1'b0;
    end
  end

  assign w_entry = (w_next != r_state) || w_turn_start;

  // Output decode of the next state, registered so the motor stage sees
  // glitch-free levels that change together with state_o.
  always_comb begin
    w_front    = 1'b0;
    w_turn     = 1'b0;
    w_turn_dir = 1'b0;
    w_halted   = 1'b0;
    unique case (w_next)
      S_SEEK, S_TRACK, S_STEP: w_front = 1'b1;
      S_TURN_AWAY: begin
        w_turn     = 1'b1;
        w_turn_dir = ~w_hand_next;
      end
      S_TURN_TOWARD: begin
        w_turn     = 1'b1;
        w_turn_dir = w_hand_next;
      end
      S_STUCK: w_halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_hand_q   <= 1'b0;
      r_timer    <= '0;
      r_turn_cnt <= '0;
      r_front    <= 1'b0;
      r_turn     <= 1'b0;
      r_turn_dir <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_hand_q   <= w_hand_next;
      r_front    <= w_front;
      r_turn     <= w_turn;
      r_turn_dir <= w_turn_dir;
      r_halted   <= w_halted;

      if (w_entry) begin
        r_timer <= '0;
      end else if (r_timer != TMR_W'(TMR_MAX)) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_next == S_SEEK || w_next == S_TRACK) begin
        r_turn_cnt <= '0;
      end else if (w_turn_start && (r_turn_cnt < TC_W'(MAX_TURNS))) begin
        r_turn_cnt <= r_turn_cnt + 1'b1;
      end
    end
  end

  assign front    = r_front;
  assign turn     = r_turn;
  assign turn_dir = r_turn_dir;
  assign halted   = r_halted;
  assign state_o  = r_state;

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wall_follower_ctrl
//   Directed scenarios for the wall follower plus a randomized run checked
//   cycle by cycle against a behavioural model built from the sensor and
//   navigation rules (sample-window debounce, countdown manoeuvres).
// -----------------------------------------------------------------------------
module tb_wall_follower_ctrl;

  localparam int DEBOUNCE    = 4;
  localparam int TURN_CYCLES = 8;
  localparam int STEP_CYCLES = 4;
  localparam int MAX_TURNS   = 4;

  localparam int M_IDLE   = 0;
  localparam int M_SEEK   = 1;
  localparam int M_TRACK  = 2;
  localparam int M_AWAY   = 3;
  localparam int M_TOWARD = 4;
  localparam int M_STEP   = 5;
  localparam int M_STUCK  = 6;

  localparam logic [31:0] WIN_MASK = (32'd1 << DEBOUNCE) - 32'd1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       hand_sel = 1'b0;
  logic       front_sensor = 1'b0;
  logic       left_sensor = 1'b0;
  logic       right_sensor = 1'b0;
  logic       front, turn, turn_dir, halted;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  wall_follower_ctrl #(
    .DEBOUNCE   (DEBOUNCE),
    .TURN_CYCLES(TURN_CYCLES),
    .STEP_CYCLES(STEP_CYCLES),
    .MAX_TURNS  (MAX_TURNS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .hand_sel    (hand_sel),
    .front_sensor(front_sensor),
    .left_sensor (left_sensor),
    .right_sensor(right_sensor),
    .front       (front),
    .turn        (turn),
    .turn_dir    (turn_dir),
    .halted      (halted),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit [2:0]    m_s1, m_s2, m_deb;
  logic [31:0] m_hist [3];
  int          m_nsamp;
  int          m_mode, m_left, m_turns;
  bit          m_hs;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 3; i++) m_hist[i] = '0;
    m_nsamp = 0;
    m_mode = M_IDLE; m_left = 0; m_turns = 0; m_hs = 1'b0;
  endtask

  task automatic start_turn(input int kind);
    if (m_turns >= MAX_TURNS) begin
      m_mode = M_STUCK;
    end else begin
      m_turns++;
      m_mode = kind;
      m_left = TURN_CYCLES;
    end
  endtask

  task automatic model_step();
    bit f, s;
    f = m_deb[0];
    s = m_hs ? m_deb[2] : m_deb[1];
    if (!enable) begin
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE:  begin m_mode = M_SEEK; m_hs = hand_sel; m_turns = 0; end
        M_SEEK:  if (f) start_turn(M_AWAY);
                 else if (s) begin m_mode = M_TRACK; m_turns = 0; end
        M_TRACK: if (f) start_turn(M_AWAY);
                 else if (!s) start_turn(M_TOWARD);
        M_AWAY: begin
          m_left--;
          if (m_left == 0) begin
            if (f) start_turn(M_AWAY);
            else begin m_mode = s ? M_TRACK : M_SEEK; m_turns = 0; end
          end
        end
        M_TOWARD: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_STEP; m_left = STEP_CYCLES; end
        end
        M_STEP: begin
          if (f) start_turn(M_AWAY);
          else begin
            m_left--;
            if (m_left == 0) begin
              if (s) begin m_mode = M_TRACK; m_turns = 0; end
              else start_turn(M_TOWARD);
            end
          end
        end
        default: ;
      endcase
    end
    // Debounced value flips once the last DEBOUNCE synced samples all disagree.
    if (m_nsamp < 1000) m_nsamp++;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][30:0], m_s2[i]};
      if (m_nsamp >= DEBOUNCE &&
          (m_hist[i] & WIN_MASK) == (m_deb[i] ? 32'd0 : WIN_MASK))
        m_deb[i] = ~m_deb[i];
    end
    m_s2 = m_s1;
    m_s1 = {right_sensor, left_sensor, front_sensor};
  endtask

  function automatic logic [6:0] model_out();
    logic f_o, t_o, d_o, h_o;
    f_o = (m_mode == M_SEEK || m_mode == M_TRACK || m_mode == M_STEP);
    t_o = (m_mode == M_AWAY || m_mode == M_TOWARD);
    d_o = (m_mode == M_AWAY) ? ~m_hs : ((m_mode == M_TOWARD) ? m_hs : 1'b0);
    h_o = (m_mode == M_STUCK);
    return {f_o, t_o, d_o, h_o, 3'(m_mode)};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({front, turn, turn_dir, halted, state_o} !== 7'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {front, turn, turn_dir, halted, state_o});
    end
    reset_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (state_o !== 3'd0 || front !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_disabled: got state %0d front %b expected state 0 front 0", state_o, front);
    end
  endtask

  task automatic test_seek_track();
    int n;
    hand_sel = 1'b0; left_sensor = 1'b1; front_sensor = 1'b0; right_sensor = 1'b0;
    enable = 1'b1;
    tick();
    n_checks++;
    if (state_o !== 3'd1 || front !== 1'b1 || turn !== 1'b0) begin
      n_errors++;
      $display("FAIL seek_entry: got state %0d front %b turn %b expected state 1 front 1 turn 0", state_o, front, turn);
    end
    n = 1;
    while (state_o !== 3'd2 && n < 2 + DEBOUNCE + 1) begin
      tick();
      n++;
    end
    n_checks++;
    if (state_o !== 3'd2) begin
      n_errors++;
      $display("FAIL track_latency: got state %0d after %0d cycles expected state 2", state_o, n);
    end
    repeat (5) tick();
    n_checks++;
    if (state_o !== 3'd2 || front !== 1'b1) begin
      n_errors++;
      $display("FAIL track_hold: got state %0d front %b expected state 2 front 1", state_o, front);
    end
  endtask

  task automatic test_glitch();
    int bad;
    bad = 0;
    front_sensor = 1'b1;
    repeat (3) begin
      tick();
      if (state_o !== 3'd2 || turn !== 1'b0) bad++;
    end
    front_sensor = 1'b0;
    repeat (10) begin
      tick();
      if (state_o !== 3'd2 || turn !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL glitch_reject: got %0d cycles off TRACK expected 0", bad);
    end
  endtask

  task automatic test_turn_away(input logic exp_dir);
    int n, bad_dir;
    front_sensor = 1'b1;
    repeat (5) tick();
    front_sensor = 1'b0;
    n = 0;
    while (turn !== 1'b1 && n < 12) begin tick(); n++; end
    n_checks++;
    if (turn !== 1'b1) begin
      n_errors++;
      $display("FAIL away_start: got turn %b expected 1 within 12 cycles", turn);
    end
    n = 0; bad_dir = 0;
    while (turn === 1'b1 && n < 40) begin
      if (turn_dir !== exp_dir || state_o !== 3'd3) bad_dir++;
      n++;
      tick();
    end
    n_checks++;
    if (n !== TURN_CYCLES || bad_dir !== 0) begin
      n_errors++;
      $display("FAIL away_len: got %0d cycles (%0d bad dir) expected %0d dir %b", n, bad_dir, TURN_CYCLES, exp_dir);
    end
    n_checks++;
    if (state_o !== 3'd2 || front !== 1'b1) begin
      n_errors++;
      $display("FAIL away_return: got state %0d expected 2", state_o);
    end
  endtask

  task automatic test_turn_toward(input logic hand);
    int n, bad;
    if (hand) right_sensor = 1'b0; else left_sensor = 1'b0;
    repeat (6) tick();
    if (hand) right_sensor = 1'b1; else left_sensor = 1'b1;
    n = 0;
    while (turn !== 1'b1 && n < 12) begin tick(); n++; end
    n_checks++;
    if (turn !== 1'b1) begin
      n_errors++;
      $display("FAIL toward_start: got turn %b expected 1 within 12 cycles", turn);
    end
    n = 0; bad = 0;
    while (turn === 1'b1 && n < 40) begin
      if (turn_dir !== hand || state_o !== 3'd4) bad++;
      n++;
      tick();
    end
    n_checks++;
    if (n !== TURN_CYCLES || bad !== 0) begin
      n_errors++;
      $display("FAIL toward_len: got %0d cycles (%0d bad) expected %0d dir %b", n, bad, TURN_CYCLES, hand);
    end
    n = 0; bad = 0;
    while (state_o === 3'd5 && n < 40) begin
      if (front !== 1'b1 || turn !== 1'b0) bad++;
      n++;
      tick();
    end
    n_checks++;
    if (n !== STEP_CYCLES || bad !== 0) begin
      n_errors++;
      $display("FAIL step_len: got %0d cycles (%0d bad) expected %0d", n, bad, STEP_CYCLES);
    end
    n_checks++;
    if (state_o !== 3'd2) begin
      n_errors++;
      $display("FAIL step_return: got state %0d expected 2", state_o);
    end
  endtask

  task automatic test_stuck();
    int n;
    front_sensor = 1'b1; left_sensor = 1'b1; right_sensor = 1'b1;
    n = 0;
    while (turn !== 1'b1 && n < 12) begin tick(); n++; end
    n = 0;
    while (turn === 1'b1 && n < 100) begin n++; tick(); end
    n_checks++;
    if (n !== MAX_TURNS * TURN_CYCLES) begin
      n_errors++;
      $display("FAIL stuck_turn_cycles: got %0d expected %0d", n, MAX_TURNS * TURN_CYCLES);
    end
    repeat (4) tick();
    n_checks++;
    if (halted !== 1'b1 || state_o !== 3'd6 || front !== 1'b0 || turn !== 1'b0) begin
      n_errors++;
      $display("FAIL stuck_hold: got halted %b state %0d expected halted 1 state 6", halted, state_o);
    end
    enable = 1'b0;
    tick();
    n_checks++;
    if (halted !== 1'b0 || state_o !== 3'd0) begin
      n_errors++;
      $display("FAIL stuck_release: got halted %b state %0d expected halted 0 state 0", halted, state_o);
    end
    front_sensor = 1'b0; left_sensor = 1'b0; right_sensor = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_right_hand();
    int n;
    hand_sel = 1'b1; right_sensor = 1'b1;
    enable = 1'b1;
    n = 0;
    while (state_o !== 3'd2 && n < 12) begin tick(); n++; end
    n_checks++;
    if (state_o !== 3'd2) begin
      n_errors++;
      $display("FAIL right_track: got state %0d expected 2", state_o);
    end
    hand_sel = 1'b0;  // must not affect the running rule
    test_turn_away(1'b0);
    test_turn_toward(1'b1);
  endtask

  task automatic test_reset_mid_turn();
    int n;
    front_sensor = 1'b1;
    n = 0;
    while (turn !== 1'b1 && n < 12) begin tick(); n++; end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({front, turn, turn_dir, halted, state_o} !== 7'd0 || n >= 12) begin
      n_errors++;
      $display("FAIL reset_mid_turn: got %b (wait %0d) expected 0000000", {front, turn, turn_dir, halted, state_o}, n);
    end
    front_sensor = 1'b0; right_sensor = 1'b0; left_sensor = 1'b0;
    enable = 1'b0; hand_sel = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    int bad, shown;
    logic [6:0] exp_v;
    bad = 0; shown = 0;
    enable = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      tick();
      exp_v = model_out();
      n_checks++;
      if ({front, turn, turn_dir, halted, state_o} !== exp_v) begin
        n_errors++;
        if (shown < 10) begin
          $display("FAIL random_cycle %0d: got %b expected %b", c, {front, turn, turn_dir, halted, state_o}, exp_v);
          shown++;
        end
      end
      if ($urandom_range(7) == 0) front_sensor = ~front_sensor;
      if ($urandom_range(7) == 0) left_sensor  = ~left_sensor;
      if ($urandom_range(7) == 0) right_sensor = ~right_sensor;
      if (enable) begin
        if ($urandom_range(99) == 0) enable = 1'b0;
      end else if ($urandom_range(3) == 0) begin
        enable = 1'b1;
      end
      hand_sel = 1'($urandom_range(1));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_seek_track();
    test_glitch();
    test_turn_away(1'b1);
    test_turn_toward(1'b0);
    test_stuck();
    test_right_hand();
    test_reset_mid_turn();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
